// File: rtl/prenc_pkg.sv
// Shared types and helpers for the registered priority-encoder / round-robin arbiter.
package prenc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Index width for n requesters; never below one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prenc_pick.sv
// Combinational winner selection: scans downward from a start index with wraparound.
module prenc_pick
   import prenc_pkg::*;
#(
   parameter int N = 6,
   localparam int W = idx_w(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   input  logic         mode_i,
   output logic [W-1:0] idx_o,
   output logic         found_o,
   output logic         multi_o
);

   logic [W-1:0] start;
   int           cand;

   // Fixed priority is the round-robin scan anchored at N-1.
   always_comb begin
      start   = W'(N - 1);
      idx_o   = '0;
      found_o = 1'b0;
      cand    = 0;
      if (mode_i == MODE_RR && int'(ptr_i) < N) begin
         start = ptr_i;
      end
      for (int i = 0; i < N; i++) begin
         cand = int'(start) - i;
         if (cand < 0) begin
            cand = cand + N;
         end
         if (!found_o && req_i[cand]) begin
            found_o = 1'b1;
            idx_o   = W'(cand);
         end
      end
   end

   // Clearing the lowest set bit leaves something iff two or more bits were set.
   assign multi_o = (req_i & (req_i - N'(1))) != '0;

endmodule

// File: rtl/prenc_rr_arb.sv
// Registered N-input arbiter: fixed-priority or round-robin winner held until acknowledged.
module prenc_rr_arb
   import prenc_pkg::*;
#(
   parameter int N = 6,
   localparam int W = idx_w(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         mode,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] grant,
   output logic         multi,
   output state_e       dbg_state_o
);

   // Handshake: a grant transfers on any rising edge where out_valid and out_ready
   // are both 1; the held grant never changes or drops before that edge.

   state_e       state_q, state_d;
   logic [W-1:0] ptr_q, ptr_d;
   logic [W-1:0] idx_q, idx_d;
   logic [N-1:0] grant_q, grant_d;
   logic         valid_q, valid_d;
   logic         multi_q, multi_d;
   logic         mode_q, mode_d;

   logic         handshake;
   logic [W-1:0] pick_idx;
   logic         pick_found;
   logic         pick_multi;

   assign handshake = valid_q & out_ready;

   // The pointer update takes effect in the handshake cycle so back-to-back picks see it.
   always_comb begin
      ptr_d = ptr_q;
      if (handshake && mode_q == MODE_RR) begin
         ptr_d = (idx_q == '0) ? W'(N - 1) : idx_q - 1'b1;
      end
   end

   prenc_pick #(.N(N)) u_pick (
      .req_i   (req),
      .ptr_i   (ptr_d),
      .mode_i  (mode),
      .idx_o   (pick_idx),
      .found_o (pick_found),
      .multi_o (pick_multi)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      grant_d = grant_q;
      valid_d = valid_q;
      multi_d = multi_q;
      mode_d  = mode_q;
      if (state_q == IDLE || handshake) begin
         if (pick_found) begin
            state_d          = HOLD;
            idx_d            = pick_idx;
            grant_d          = '0;
            grant_d[pick_idx] = 1'b1;
            valid_d          = 1'b1;
            multi_d          = pick_multi;
            mode_d           = mode;
         end else begin
            state_d = IDLE;
            idx_d   = '0;
            grant_d = '0;
            valid_d = 1'b0;
            multi_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= W'(N - 1);
         idx_q   <= '0;
         grant_q <= '0;
         valid_q <= 1'b0;
         multi_q <= 1'b0;
         mode_q  <= MODE_FIXED;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
         multi_q <= multi_d;
         mode_q  <= mode_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_idx     = idx_q;
   assign grant       = grant_q;
   assign multi       = multi_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_prenc_rr_arb.sv
// Directed bench for prenc_rr_arb with a 6-input and a 5-input instance.
module tb_prenc_rr_arb;
   import prenc_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic         mode;
   logic         out_ready;
   logic [5:0]   req6;
   logic [4:0]   req5;
   logic         valid6, valid5;
   logic [2:0]   idx6, idx5;
   logic [5:0]   grant6;
   logic [4:0]   grant5;
   logic         multi6, multi5;
   state_e       st6, st5;

   int           checks = 0;
   int           errors = 0;
   logic [31:0]  exp_q[$];
   logic [31:0]  e;

   always #5 clk = ~clk;

   prenc_rr_arb #(.N(6)) u6 (
      .clk(clk), .rst(rst), .req(req6), .mode(mode), .out_ready(out_ready),
      .out_valid(valid6), .out_idx(idx6), .grant(grant6), .multi(multi6),
      .dbg_state_o(st6)
   );

   prenc_rr_arb #(.N(5)) u5 (
      .clk(clk), .rst(rst), .req(req5), .mode(mode), .out_ready(out_ready),
      .out_valid(valid5), .out_idx(idx5), .grant(grant5), .multi(multi5),
      .dbg_state_o(st5)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check6(input string tag, input logic v, input logic [2:0] i,
                         input logic [5:0] g, input logic m);
      check({tag, ".valid"}, 32'(valid6), 32'(v));
      check({tag, ".idx"},   32'(idx6),   32'(i));
      check({tag, ".grant"}, 32'(grant6), 32'(g));
      check({tag, ".multi"}, 32'(multi6), 32'(m));
   endtask

   initial begin
      rst = 1'b1; mode = MODE_FIXED; out_ready = 1'b0; req6 = '0; req5 = '0;

      // 1. reset and idle
      tick(); tick();
      check6("rst6", 1'b0, 3'd0, 6'b000000, 1'b0);
      check("rst5.valid", 32'(valid5), 0);
      check("rst.state", 32'(st6), 32'(IDLE));
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check6("idle6", 1'b0, 3'd0, 6'b000000, 1'b0);
         check("idle5.valid", 32'(valid5), 0);
      end

      // 2. fixed priority, held without ready
      req6 = 6'b101100;
      tick();
      check6("fix_sel", 1'b1, 3'd5, 6'b100000, 1'b1);
      check("fix_sel.state", 32'(st6), 32'(HOLD));
      req6 = 6'b000001;
      mode = MODE_RR;
      for (int k = 0; k < 3; k++) begin
         tick();
         check6("fix_hold", 1'b1, 3'd5, 6'b100000, 1'b1);
      end

      // async reset mid-HOLD, observed between edges
      #2;
      rst = 1'b1;
      #1;
      check6("async_rst", 1'b0, 3'd0, 6'b000000, 1'b0);
      check("async_rst.state", 32'(st6), 32'(IDLE));
      tick();
      rst = 1'b0;
      req6 = '0;
      mode = MODE_FIXED;
      tick();

      // 3. fixed-priority starvation, back-to-back
      out_ready = 1'b1;
      req6 = 6'b000011;
      for (int k = 0; k < 4; k++) begin
         tick();
         check6("starve", 1'b1, 3'd1, 6'b000010, 1'b1);
      end
      req6 = '0;
      tick();
      check6("starve_end", 1'b0, 3'd0, 6'b000000, 1'b0);

      // 4. round-robin wrap; pointer still N-1 since mode 0 never moves it
      mode = MODE_RR;
      req6 = 6'b100001;
      exp_q = '{32'd5, 32'd0, 32'd5, 32'd0};
      while (exp_q.size() > 0) begin
         tick();
         e = exp_q.pop_front();
         check("rr_wrap.idx", 32'(idx6), e);
         check("rr_wrap.grant", 32'(grant6), 32'(1) << e);
         check("rr_wrap.valid", 32'(valid6), 1);
      end
      req6 = '0;
      tick();
      check("rr_wrap_end.valid", 32'(valid6), 0);

      // 5. round-robin full load with a stall
      req6 = 6'b111111;
      exp_q = '{32'd5, 32'd4, 32'd3};
      while (exp_q.size() > 0) begin
         tick();
         e = exp_q.pop_front();
         check("rr_full.idx", 32'(idx6), e);
         check("rr_full.multi", 32'(multi6), 1);
      end
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         check6("rr_stall", 1'b1, 3'd3, 6'b001000, 1'b1);
      end
      out_ready = 1'b1;
      exp_q = '{32'd2, 32'd1, 32'd0, 32'd5};
      while (exp_q.size() > 0) begin
         tick();
         e = exp_q.pop_front();
         check("rr_resume.idx", 32'(idx6), e);
         check("rr_resume.grant", 32'(grant6), 32'(1) << e);
         check("rr_resume.multi", 32'(multi6), 1);
      end
      req6 = '0;
      tick();
      check("rr_full_end.valid", 32'(valid6), 0);

      // 6. non-power-of-two instance
      req5 = 5'b10001;
      exp_q = '{32'd4, 32'd0, 32'd4, 32'd0};
      while (exp_q.size() > 0) begin
         tick();
         e = exp_q.pop_front();
         check("n5_rr.idx", 32'(idx5), e);
         check("n5_rr.range", 32'(idx5 < 3'd5), 1);
         check("n5_rr.grant", 32'(grant5), 32'(1) << e);
      end
      req5 = '0;
      tick();
      check("n5_idle.valid", 32'(valid5), 0);
      req5 = 5'b00100;
      tick();
      check("n5_single.valid", 32'(valid5), 1);
      check("n5_single.idx", 32'(idx5), 2);
      check("n5_single.grant", 32'(grant5), 32'b00100);
      check("n5_single.multi", 32'(multi5), 0);
      req5 = '0;
      tick();
      check("n5_end.valid", 32'(valid5), 0);
      check("n6_quiet.valid", 32'(valid6), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prenc_rr_arb.md
Name: prenc_rr_arb

Overview:
- Parametrised, registered successor to the 6-input priority encoder.
- Takes N request lines and selects one winner, either by fixed priority (highest index wins) or by round-robin.
- Presents the winner as a binary index plus a one-hot grant, with a valid/ready handshake.
- Sits between request sources (interrupt lines, bus masters) and a single consumer that acknowledges each grant.

Parameters:
- N, 6, number of request lines; legal range 2..32, powers of two not required.
- W, $clog2(N), width of the winner index; derived, not to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req  input  N  request vector; bit k set means requester k wants service.
- mode  input  1  0 = fixed priority (MSB highest), 1 = round-robin.
- out_ready  input  1  consumer accepts the current grant this cycle.
- out_valid  output  1  a grant is presented.
- out_idx  output  W  binary index of the granted requester.
- grant  output  N  one-hot copy of out_idx; all zero when out_valid=0.
- multi  output  1  more than one req bit was set when the current grant was chosen.

Behaviour:
- Reset (asynchronous, immediate):
  - out_valid=0, out_idx=0, grant=0, multi=0.
  - State IDLE, round-robin pointer ptr=N-1.
- States:
  - IDLE: no grant presented.
  - HOLD: grant presented and waiting for the handshake.
- IDLE transitions:
  - req==0: stay in IDLE, outputs unchanged.
  - req!=0: choose a winner from req, mode and ptr. On the next edge, register out_idx, grant, multi and out_valid=1, then go to HOLD.
  - Latency from request to out_valid is exactly 1 cycle.
- HOLD transitions:
  - While out_ready=0, all outputs are held stable.
  - Changes on req or mode do not revoke or alter the held grant. No revocation.
- Handshake (out_valid & out_ready at an edge):
  - If mode was 1 at selection, ptr becomes (out_idx-1) mod N. An index of 0 wraps to N-1.
  - If mode was 0, ptr is unchanged.
  - If req!=0 in the handshake cycle, select a new winner using the updated ptr, register it and stay in HOLD. This gives back-to-back grants, one per cycle, with no bubble.
  - If req==0, go to IDLE with out_valid=0, grant=0, out_idx=0, multi=0.
- Selection rules:
  - mode=0: the highest set bit of req wins.
  - mode=1: scan order is ptr, ptr-1, ..., 0, N-1, ..., ptr+1, and the first set bit wins. With ptr=N-1 this equals fixed priority.
  - The selection used in a cycle is a pure function of (req, mode, ptr) in that cycle.
  - out_idx is always < N. Values ≥ N are never produced.
  - grant == (1 << out_idx) whenever out_valid=1.
- multi is registered together with the winner: it is 1 iff popcount(req) ≥ 2 at selection time.
- mode is sampled only at selection. Switching mode mid-HOLD has no effect until the next selection.
- A requester dropping its req while granted is still served until the handshake. out_ready with out_valid=0 is ignored.
- Reset mid-HOLD clears outputs asynchronously, before the next edge. After release, the first selection uses ptr=N-1.

Decomposition:
- Package prenc_pkg:
  - State typedef (IDLE, HOLD).
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - Index-width helper function.
- Sub-module prenc_pick (combinational):
  - Inputs req[N], ptr[W], mode.
  - Outputs idx[W], found, multi.
  - Rotate-and-scan implementation.
- The top level holds the FSM, ptr register and output registers.

Test Plan:
1. Reset and idle: rst=1 for 2 cycles, release, req=0 for 3 cycles -> out_valid=0, grant=6'b000000, out_idx=0 throughout. Assert rst asynchronously mid-HOLD -> outputs clear without waiting for clk.
2. Fixed priority with hold (N=6, mode=0, out_ready=0): req=6'b101100 -> one cycle later out_valid=1, out_idx=5, grant=6'b100000, multi=1. Change req to 6'b000001 -> outputs unchanged for 3 cycles.
3. Fixed-priority starvation (mode=0, out_ready=1): req=6'b000011 held -> out_idx=1 every cycle, out_valid stays 1 (back-to-back), multi=1. Then req=0 -> out_valid=0 on the cycle after the handshake.
4. Round-robin wrap (mode=1, out_ready=1): req=6'b100001 held -> out_idx sequence 5,0,5,0. Pointer wraps from out_idx=0 to ptr=5.
5. Round-robin full load (mode=1, out_ready=1): req=6'b111111 -> out_idx 5,4,3,2,1,0,5 on consecutive cycles, multi=1 each. Toggle out_ready=0 mid-sequence -> grant held, and the sequence resumes where it stopped.
6. Non-power-of-two (N=5, W=3, mode=1): req=5'b10001 -> out_idx alternates 4,0 and never reaches 5..7. Single request req=5'b00100 -> out_idx=2, multi=0.
